// File: rtl/wdog_pkg.sv
// Shared definitions for the watchdog timer: FSM states,
// register map, bit positions and the default kick key.
package wdog_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        WARN   = 2'd2,
        EXPIRE = 2'd3
    } wdog_state_e;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_LOAD = 2'd1;
    localparam logic [1:0] ADDR_KICK = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int CTRL_ENB    = 0;
    localparam int CTRL_RST_EN = 1;
    localparam int CTRL_LOCK   = 2;

    localparam int ST_WARN = 0;
    localparam int ST_TOUT = 1;

    localparam logic [31:0] KICK_KEY_DEF = 32'h5A5A_A5A5;

endpackage

// File: rtl/wdog_reg.sv
// Watchdog register bank: CTRL/LOAD/KICK/STATUS, lock, W1C flags.
// Ports: reg bus in/out, count/state readback, hw flag sets and
// enb clear from the FSM, decoded config and kick strobe out.
// Access: request captured when reg_cs is sampled, reg_ack and
// read data follow one cycle later, writes land at the end of the
// ack cycle. Optional WDOG_WINDOW_EN adds CTRL[31:16] win_ms.
module wdog_reg
    import wdog_pkg::*;
#(
    parameter logic [31:0] KICK_KEY = KICK_KEY_DEF
) (
    input  logic        mclk,
    input  logic        h_reset,
    input  logic        reg_cs,
    input  logic        reg_wr,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic [3:0]  reg_be,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    input  logic [15:0] count,
    input  logic [1:0]  state,
    input  logic        warn_set,
    input  logic        tout_set,
    input  logic        enb_clr,
    output logic        enb,
    output logic        rst_en,
    output logic        lock,
    output logic [15:0] tout_ms,
    output logic [15:0] warn_ms,
    output logic [15:0] win_ms,
    output logic        kick,
    output logic        warn_flag,
    output logic        tout_flag
);

    logic        wr_q;
    logic [1:0]  addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rd_mux;
    logic        wr_en;
    logic        ctrl_wr;
    logic        load_wr;
    logic        stat_wr;
    logic        start;

    // A held reg_cs would otherwise retrigger during the ack cycle.
    assign start   = reg_cs && !reg_ack;
    assign wr_en   = reg_ack && wr_q;
    assign ctrl_wr = wr_en && (addr_q == ADDR_CTRL) && !lock;
    assign load_wr = wr_en && (addr_q == ADDR_LOAD) && !lock;
    assign stat_wr = wr_en && (addr_q == ADDR_STAT) && be_q[0];
    assign kick    = wr_en && (addr_q == ADDR_KICK)
                  && (be_q == 4'hF) && (wdata_q == KICK_KEY);

    always_comb begin
        rd_mux = 32'h0;
        unique case (reg_addr)
            ADDR_CTRL: begin
                rd_mux[31:16]       = win_ms;
                rd_mux[CTRL_ENB]    = enb;
                rd_mux[CTRL_RST_EN] = rst_en;
                rd_mux[CTRL_LOCK]   = lock;
            end
            ADDR_LOAD: rd_mux = {warn_ms, tout_ms};
            ADDR_KICK: rd_mux = {16'h0, count};
            ADDR_STAT: begin
                rd_mux[ST_WARN] = warn_flag;
                rd_mux[ST_TOUT] = tout_flag;
                rd_mux[3:2]     = state;
            end
            default: ;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            reg_ack   <= 1'b0;
            reg_rdata <= 32'h0;
            wr_q      <= 1'b0;
            addr_q    <= 2'd0;
            wdata_q   <= 32'h0;
            be_q      <= 4'h0;
        end else begin
            reg_ack   <= start;
            reg_rdata <= (start && !reg_wr) ? rd_mux : 32'h0;
            if (start) begin
                wr_q    <= reg_wr;
                addr_q  <= reg_addr;
                wdata_q <= reg_wdata;
                be_q    <= reg_be;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            enb       <= 1'b0;
            rst_en    <= 1'b0;
            lock      <= 1'b0;
            tout_ms   <= 16'h0;
            warn_ms   <= 16'h0;
            warn_flag <= 1'b0;
            tout_flag <= 1'b0;
        end else begin
            if (ctrl_wr && be_q[0]) begin
                enb    <= wdata_q[CTRL_ENB];
                rst_en <= wdata_q[CTRL_RST_EN];
                if (wdata_q[CTRL_LOCK])
                    lock <= 1'b1;
            end
            // Leaving EXPIRE disarms; a locked block stays armed.
            if (enb_clr && !lock)
                enb <= 1'b0;
            if (load_wr) begin
                if (be_q[0]) tout_ms[7:0]  <= wdata_q[7:0];
                if (be_q[1]) tout_ms[15:8] <= wdata_q[15:8];
                if (be_q[2]) warn_ms[7:0]  <= wdata_q[23:16];
                if (be_q[3]) warn_ms[15:8] <= wdata_q[31:24];
            end
            // Hardware set is ORed in last so it beats a W1C.
            warn_flag <= (warn_flag
                       & ~(stat_wr & wdata_q[ST_WARN])) | warn_set;
            tout_flag <= (tout_flag
                       & ~(stat_wr & wdata_q[ST_TOUT])) | tout_set;
        end
    end

`ifdef WDOG_WINDOW_EN
    always_ff @(posedge mclk) begin
        if (h_reset) begin
            win_ms <= 16'h0;
        end else if (ctrl_wr) begin
            if (be_q[2]) win_ms[7:0]  <= wdata_q[23:16];
            if (be_q[3]) win_ms[15:8] <= wdata_q[31:24];
        end
    end
`else
    assign win_ms = 16'h0;
`endif

endmodule

// File: rtl/wdog_timer.sv
// Watchdog timer: 16-bit ms down-counter with keyed kick,
// pre-timeout warning interrupt and a fixed-width reset request.
// Ports: mclk/h_reset, 2-bit-address register bus, pulse_1ms tick
// in, wdt_intr level interrupt and wdt_rst_req pulse out.
// WDOG_WINDOW_EN enables the early-kick window check.
module wdog_timer
    import wdog_pkg::*;
#(
    parameter int unsigned RST_CYC  = 16,
    parameter logic [31:0] KICK_KEY = KICK_KEY_DEF
) (
    input  logic        mclk,
    input  logic        h_reset,
    input  logic        reg_cs,
    input  logic        reg_wr,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic [3:0]  reg_be,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    input  logic        pulse_1ms,
    output logic        wdt_intr,
    output logic        wdt_rst_req
);

    localparam logic [7:0] RCYC_M1 = 8'(RST_CYC - 1);

    wdog_state_e state;
    wdog_state_e state_d;
    logic [15:0] count;
    logic [15:0] count_d;
    logic [15:0] dec;
    logic [7:0]  rcnt;
    logic [7:0]  rcnt_d;
    logic        rreq_d;
    logic        enb;
    logic        rst_en;
    logic        lock;
    logic [15:0] tout_ms;
    logic [15:0] warn_ms;
    logic [15:0] win_ms;
    logic        kick;
    logic        early;
    logic        warn_set;
    logic        tout_set;
    logic        enb_clr;
    logic        warn_flag;
    logic        tout_flag;

    wdog_reg #(
        .KICK_KEY (KICK_KEY)
    ) u_reg (
        .mclk      (mclk),
        .h_reset   (h_reset),
        .reg_cs    (reg_cs),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_be    (reg_be),
        .reg_rdata (reg_rdata),
        .reg_ack   (reg_ack),
        .count     (count),
        .state     (state),
        .warn_set  (warn_set),
        .tout_set  (tout_set),
        .enb_clr   (enb_clr),
        .enb       (enb),
        .rst_en    (rst_en),
        .lock      (lock),
        .tout_ms   (tout_ms),
        .warn_ms   (warn_ms),
        .win_ms    (win_ms),
        .kick      (kick),
        .warn_flag (warn_flag),
        .tout_flag (tout_flag)
    );

    assign wdt_intr = warn_flag | tout_flag;
    // win_ms is tied to zero when the window feature is absent.
    assign early    = (win_ms != 16'h0) && (count > win_ms);
    assign dec      = (count == 16'h0) ? 16'h0 : count - 16'h1;
    assign tout_set = (state != EXPIRE) && (state_d == EXPIRE);

    always_comb begin
        state_d  = state;
        count_d  = count;
        rcnt_d   = rcnt;
        rreq_d   = wdt_rst_req;
        warn_set = 1'b0;
        enb_clr  = 1'b0;
        unique case (state)
            IDLE: begin
                if (enb) begin
                    count_d = tout_ms;
                    state_d = RUN;
                end
            end
            RUN, WARN: begin
                if (!enb) begin
                    state_d = IDLE;
                end else if (kick && early) begin
                    state_d = EXPIRE;
                end else if (kick) begin
                    count_d = tout_ms;
                    state_d = RUN;
                end else if (pulse_1ms) begin
                    count_d = dec;
                    if (count <= 16'h1) begin
                        state_d = EXPIRE;
                    end else if (state == RUN
                              && warn_ms != 16'h0
                              && dec <= warn_ms) begin
                        state_d  = WARN;
                        warn_set = 1'b1;
                    end
                end
            end
            EXPIRE: begin
                if (rcnt == 8'h0) begin
                    rreq_d  = 1'b0;
                    enb_clr = 1'b1;
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt - 8'h1;
                end
            end
            default: ;
        endcase
        // rst_en is sampled once on entry to EXPIRE.
        if (tout_set) begin
            rreq_d = rst_en;
            rcnt_d = rst_en ? RCYC_M1 : 8'h0;
        end
    end

    always_ff @(posedge mclk) begin
        if (h_reset) begin
            state       <= IDLE;
            count       <= 16'h0;
            rcnt        <= 8'h0;
            wdt_rst_req <= 1'b0;
        end else begin
            state       <= state_d;
            count       <= count_d;
            rcnt        <= rcnt_d;
            wdt_rst_req <= rreq_d;
        end
    end

endmodule

// File: tb/tb_wdog_timer.sv
// Directed self-checking bench for wdog_timer.
// Linear sequence of bus/tick steps with immediate assertions.
module tb_wdog_timer;

    logic        mclk = 1'b0;
    logic        h_reset;
    logic        reg_cs;
    logic        reg_wr;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        pulse_1ms;
    logic        wdt_intr;
    logic        wdt_rst_req;

    int vecs = 0;
    int errs = 0;

    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    always #5 mclk = ~mclk;

    wdog_timer dut (
        .mclk        (mclk),
        .h_reset     (h_reset),
        .reg_cs      (reg_cs),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_be      (reg_be),
        .reg_rdata   (reg_rdata),
        .reg_ack     (reg_ack),
        .pulse_1ms   (pulse_1ms),
        .wdt_intr    (wdt_intr),
        .wdt_rst_req (wdt_rst_req)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        reg_cs = 1'b1; reg_wr = 1'b1;
        reg_addr = a; reg_wdata = d; reg_be = be;
        step(1);
        reg_cs = 1'b0; reg_wr = 1'b0;
        step(1);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = a;
        step(1);
        d = reg_ack ? reg_rdata : 32'hDEAD_BEEF;
        reg_cs = 1'b0;
        step(1);
    endtask

    task automatic rchk(input string tag, input logic [1:0] a,
                        input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            pulse_1ms = 1'b1;
            step(1);
            pulse_1ms = 1'b0;
        end
    endtask

    initial begin
        int n;
        h_reset = 1'b1; reg_cs = 1'b0; reg_wr = 1'b0;
        reg_addr = 2'd0; reg_wdata = 32'h0; reg_be = 4'h0;
        pulse_1ms = 1'b0;
        step(2);
        h_reset = 1'b0;
        chk("rst_ack", {31'h0, reg_ack}, 32'h0);
        chk("rst_rdata", reg_rdata, 32'h0);
        chk("rst_intr", {31'h0, wdt_intr}, 32'h0);
        chk("rst_req", {31'h0, wdt_rst_req}, 32'h0);
        rchk("rst_ctrl", 2'd0, 32'h0);
        rchk("rst_stat", 2'd3, 32'h0);
        rchk("rst_count", 2'd2, 32'h0);

        wr(2'd1, 32'h1234_5678, 4'b0101);
        rchk("load_be", 2'd1, 32'h0034_0078);

        // Plain expiry with reset request
        wr(2'd1, 32'h0000_0005, 4'hF);
        wr(2'd0, 32'h0000_0003, 4'h1);
        step(1);
        rchk("t1_run", 2'd3, 32'h4);
        tick(4);
        rchk("t1_cnt1", 2'd2, 32'h1);
        chk("t1_noreq", {31'h0, wdt_rst_req}, 32'h0);
        tick(1);
        chk("t1_req", {31'h0, wdt_rst_req}, 32'h1);
        chk("t1_intr", {31'h0, wdt_intr}, 32'h1);
        n = 0;
        while (wdt_rst_req && n < 40) begin
            n++;
            step(1);
        end
        chk("t1_width", n, 32'd16);
        rchk("t1_ctrl", 2'd0, 32'h2);
        rchk("t1_stat", 2'd3, 32'h2);
        wr(2'd3, 32'h3, 4'h1);
        chk("t1_clr", {31'h0, wdt_intr}, 32'h0);

        // Warning then kick
        wr(2'd1, 32'h0003_000A, 4'hF);
        wr(2'd0, 32'h0000_0001, 4'h1);
        step(1);
        tick(6);
        chk("t2_nowarn", {31'h0, wdt_intr}, 32'h0);
        tick(1);
        chk("t2_warn", {31'h0, wdt_intr}, 32'h1);
        rchk("t2_stat", 2'd3, 32'h9);
        rchk("t2_cnt", 2'd2, 32'h3);
        wr(2'd2, KEY, 4'hF);
        rchk("t2_kick", 2'd2, 32'hA);
        rchk("t2_stat2", 2'd3, 32'h5);
        wr(2'd3, 32'h1, 4'h1);
        chk("t2_clr", {31'h0, wdt_intr}, 32'h0);
        chk("t2_noreq", {31'h0, wdt_rst_req}, 32'h0);
        wr(2'd0, 32'h0, 4'h1);
        step(1);
        rchk("t2_idle", 2'd3, 32'h0);
        rchk("t2_hold", 2'd2, 32'hA);

        // Invalid kicks
        wr(2'd1, 32'h0000_0004, 4'hF);
        wr(2'd0, 32'h0000_0001, 4'h1);
        step(1);
        tick(1);
        wr(2'd2, 32'h1234_5678, 4'hF);
        rchk("t3_badkey", 2'd2, 32'h3);
        wr(2'd2, KEY, 4'b0111);
        rchk("t3_badbe", 2'd2, 32'h3);
        tick(3);
        chk("t3_exp", {31'h0, wdt_intr}, 32'h1);
        chk("t3_noreq", {31'h0, wdt_rst_req}, 32'h0);
        step(1);
        rchk("t3_stat", 2'd3, 32'h2);
        rchk("t3_ctrl", 2'd0, 32'h0);
        wr(2'd3, 32'h2, 4'h1);

        // Lock and auto re-arm
        wr(2'd1, 32'h0000_0003, 4'hF);
        wr(2'd0, 32'h0000_0007, 4'h1);
        step(1);
        wr(2'd0, 32'h0, 4'hF);
        rchk("t4_ctrl", 2'd0, 32'h7);
        wr(2'd1, 32'h0000_0009, 4'hF);
        rchk("t4_load", 2'd1, 32'h3);
        tick(3);
        chk("t4_req", {31'h0, wdt_rst_req}, 32'h1);
        step(20);
        rchk("t4_ctrl2", 2'd0, 32'h7);
        rchk("t4_stat", 2'd3, 32'h6);
        rchk("t4_rearm", 2'd2, 32'h3);

        // Kick coincident with expiring tick
        wr(2'd3, 32'h3, 4'h1);
        tick(2);
        rchk("t5_cnt1", 2'd2, 32'h1);
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 2'd2;
        reg_wdata = KEY; reg_be = 4'hF;
        step(1);
        reg_cs = 1'b0; reg_wr = 1'b0; pulse_1ms = 1'b1;
        step(1);
        pulse_1ms = 1'b0;
        chk("t5_noreq", {31'h0, wdt_rst_req}, 32'h0);
        chk("t5_nointr", {31'h0, wdt_intr}, 32'h0);
        rchk("t5_cnt", 2'd2, 32'h3);
        rchk("t5_stat", 2'd3, 32'h4);

        // Reset during EXPIRE
        tick(3);
        step(3);
        chk("t6_req", {31'h0, wdt_rst_req}, 32'h1);
        h_reset = 1'b1;
        step(1);
        chk("t6_drop", {31'h0, wdt_rst_req}, 32'h0);
        h_reset = 1'b0;
        rchk("t6_ctrl", 2'd0, 32'h0);

`ifdef WDOG_WINDOW_EN
        wr(2'd1, 32'h0000_000A, 4'hF);
        wr(2'd0, 32'h0004_0001, 4'hF);
        step(1);
        tick(2);
        wr(2'd2, KEY, 4'hF);
        chk("w_early", {31'h0, wdt_intr}, 32'h1);
        step(1);
        rchk("w_ctrl", 2'd0, 32'h0004_0000);
        wr(2'd3, 32'h3, 4'h1);
        wr(2'd0, 32'h0004_0001, 4'hF);
        step(1);
        tick(7);
        wr(2'd2, KEY, 4'hF);
        rchk("w_ok", 2'd2, 32'hA);
        chk("w_nointr", {31'h0, wdt_intr}, 32'h0);
`else
        wr(2'd0, 32'hABCD_0000, 4'hF);
        rchk("nowin_ctrl", 2'd0, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule

// File: doc/wdog_timer.md
# wdog_timer

Watchdog timer consuming the 1 ms tick (`pulse_1ms`) produced by the timer block in the pinmux subsystem. A 16-bit millisecond down-counter is reloaded by a keyed software kick. It raises a pre-timeout warning interrupt and, on expiry, a fixed-width reset-request pulse toward the reset controller. The block is programmed over the same 2-bit-address register bus as the other pinmux peripherals.

## Interface
- `RST_CYC`, default 16: `wdt_rst_req` pulse width in mclk cycles (1..255).
- `KICK_KEY`, default 32'h5A5A_A5A5: data value that constitutes a valid kick.
- `mclk`  in  1: master clock.
- `h_reset`  in  1: reset. One clock; reset is synchronous and active-high.
- `reg_cs`  in  1: register chip select.
- `reg_wr`  in  1: 1 = write, 0 = read.
- `reg_addr`  in  2: register address.
- `reg_wdata`  in  32: write data.
- `reg_be`  in  4: byte enables (writes only).
- `reg_rdata`  out  32: read data, valid with `reg_ack`.
- `reg_ack`  out  1: single-cycle access acknowledge.
- `pulse_1ms`  in  1: one-mclk-wide tick every 1 ms.
- `wdt_intr`  out  1: level interrupt, equal to `warn_flag | tout_flag`.
- `wdt_rst_req`  out  1: reset request, high for exactly `RST_CYC` cycles.

## Operation
- Registers:
  - 0 CTRL: [0] `enb`, [1] `rst_en`, [2] `lock` (set-only; write 0 is ignored).
  - 1 LOAD: [15:0] `tout_ms`, [31:16] `warn_ms`.
  - 2 KICK: write of `KICK_KEY` is a kick; any other write value is ignored. Read returns {16'h0, count}.
  - 3 STATUS: [0] `warn_flag` (W1C), [1] `tout_flag` (W1C), [3:2] state encoding (read-only).
- Byte enables gate each byte of CTRL, LOAD and STATUS. A KICK write requires all four `reg_be` bits set.
- While `lock`=1, writes to CTRL and LOAD are dropped until `h_reset`. KICK and STATUS remain writable.
- FSM states:
  - IDLE=0: on `enb`=1, load count←`tout_ms` and go to RUN.
  - RUN=1: on `pulse_1ms`, decrement the count. If the count is 1 or 0 at the tick, go to EXPIRE. Otherwise, if the new count ≤ `warn_ms` and `warn_ms`≠0, set `warn_flag` and go to WARN.
  - WARN=2: decrement as in RUN. On reaching expiry, go to EXPIRE. A kick reloads `tout_ms` and returns the FSM to RUN; `warn_flag` stays set until cleared.
  - EXPIRE=3: set `tout_flag`. If `rst_en`=1, drive `wdt_rst_req` for `RST_CYC` cycles; if `rst_en`=0, spend one cycle. Then clear `enb` (unless locked) and go to IDLE. If the block is locked, it re-arms from IDLE on the next cycle.
- In RUN or WARN, writing `enb`=0 (unlocked) returns the FSM to IDLE with the count held. EXPIRE is not interruptible.
- A kick in RUN reloads the count. A kick in IDLE or EXPIRE is ignored.
- Arithmetic: the count is unsigned 16-bit and saturates at 0; it never wraps. `tout_ms`=0 expires on the first tick after arming.

## Timing
- Reset values: all registers 0, state IDLE, count 0, `reg_ack`=0, `reg_rdata`=0, `wdt_intr`=0, `wdt_rst_req`=0.
- `reg_ack` goes high one cycle after `reg_cs` is sampled and lasts one cycle. Back-to-back accesses need `reg_cs` deasserted for one cycle between them.
- Register write effects are visible on the cycle after `reg_ack`.
- FSM transitions are registered: `wdt_rst_req` rises one cycle after the expiring `pulse_1ms`.
- Simultaneous kick and `pulse_1ms`: the kick wins. The count loads `tout_ms` with no decrement that cycle.
- Simultaneous W1C clear and a hardware flag set: the set wins.
- `h_reset` asserted mid-EXPIRE drops `wdt_rst_req` on the next edge.

## Configuration
- `WDOG_WINDOW_EN` defined: CTRL[31:16] is `win_ms`.
  - A kick while count > `win_ms` (kicked too early) is illegal and forces EXPIRE on the next cycle.
  - `win_ms`=0 disables the check.
- `WDOG_WINDOW_EN` undefined: CTRL[31:16] reads 0 and ignores writes. All kicks in RUN/WARN are legal.

## Structure
- The `wdog_pkg` package holds:
  - the state enum (IDLE/RUN/WARN/EXPIRE);
  - register address constants;
  - CTRL/STATUS bit-position localparams;
  - the `KICK_KEY` default.
- Sub-module `wdog_reg` contains the register bank, lock and W1C logic, and read mux. The top level holds the FSM, the count, and the reset-pulse counter.

## Test plan
- `tout_ms`=5, `warn_ms`=0, `rst_en`=1, `enb`=1, no kicks → `tout_flag` sets and `wdt_rst_req` goes high 16 cycles, one cycle after the 5th tick. The FSM returns to IDLE and `enb` reads 0.
- `tout_ms`=10, `warn_ms`=3 → `wdt_intr` rises after the 7th tick. A kick then reloads the count to 10. `wdt_rst_req` is never asserted, and a STATUS write of 1 clears `wdt_intr`.
- KICK write of 32'h1234_5678 → ignored, and expiry still occurs on schedule. A KICK write with `reg_be`=4'b0111 and the correct key → also ignored.
- Set `lock`, then write CTRL=0 → `enb` is still 1. After expiry, the FSM auto-rearms with count=`tout_ms`.
- Kick issued on the same cycle as `pulse_1ms` with count=1 → no expiry, and the count reads `tout_ms`.
- With `WDOG_WINDOW_EN`, `win_ms`=4, `tout_ms`=10: a kick at count=8 → EXPIRE on the next cycle. A kick at count=3 → reload to 10.
